// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter: shares framebuffer port A between two single-beat requesters
// and a built-in full-framebuffer clear sequencer that takes priority over arbitration.
module framebuffer_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int RAM_READ_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_address,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rdata_valid,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rdata_valid,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_in
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_WIDTH:0] CNT_END = (ADDR_WIDTH+1)'(DEPTH);
  state_t state, state_d;
  logic [ADDR_WIDTH:0] cnt, cnt_d;
  logic last_grant, last_grant_d;
  logic e0, e1, win1, arb, start, clr_issue;
  logic ack0_d, ack1_d, busy_d, done_d, we_d, ce_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d, hold0, hold1;
  logic [RAM_READ_LATENCY-1:0] pv, pid;

  always_ff @(posedge clk_in or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;

  always_comb
    state_d = state == IDLE ? (clear_start ? CLEAR : IDLE) : (cnt == CNT_END ? IDLE : CLEAR);

  // cnt is the next clear address; it rests at 0 so a new clear starts at address 0
  always_comb begin
    e0 = r0_req && !r0_ack;
    e1 = r1_req && !r1_ack;
    win1 = e1 && (!e0 || !last_grant);
    start = state == IDLE && clear_start;
    clr_issue = start || (state == CLEAR && cnt != CNT_END);
    arb = state == IDLE && !clear_start && (e0 || e1);
    cnt_d = clr_issue ? cnt + 1'b1 : '0;
    addr_d = clr_issue ? cnt[ADDR_WIDTH-1:0] : arb ? (win1 ? r1_address : r0_address) : ram_address;
    data_d = clr_issue ? CLEAR_VALUE : arb ? (win1 ? r1_wdata : r0_wdata) : ram_data_out;
    we_d = clr_issue || (arb && (win1 ? r1_write : r0_write));
    ce_d = clr_issue || arb;
    ack0_d = arb && !win1;
    ack1_d = arb && win1;
    last_grant_d = arb ? win1 : last_grant;
    busy_d = clr_issue;
    done_d = state == CLEAR && cnt == CNT_END;
  end

  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      cnt <= '0;
      last_grant <= 1'b1;
      ram_address <= '0;
      ram_data_out <= '0;
      ram_write_enable <= 1'b0;
      ram_clk_enable <= 1'b0;
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      cnt <= cnt_d;
      last_grant <= last_grant_d;
      ram_address <= addr_d;
      ram_data_out <= data_d;
      ram_write_enable <= we_d;
      ram_clk_enable <= ce_d;
      r0_ack <= ack0_d;
      r1_ack <= ack1_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
    end

  // During a read strobe last_grant already names the owner; clear strobes are writes
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      pv <= '0;
      pid <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      pv[0] <= ram_clk_enable && !ram_write_enable;
      pid[0] <= last_grant;
      for (int i = 1; i < RAM_READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      if (r0_rdata_valid) hold0 <= ram_data_in;
      if (r1_rdata_valid) hold1 <= ram_data_in;
    end

  assign r0_rdata_valid = pv[RAM_READ_LATENCY-1] && !pid[RAM_READ_LATENCY-1];
  assign r1_rdata_valid = pv[RAM_READ_LATENCY-1] && pid[RAM_READ_LATENCY-1];
  assign r0_rdata = r0_rdata_valid ? ram_data_in : hold0;
  assign r1_rdata = r1_rdata_valid ? ram_data_in : hold1;
endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// tb_framebuffer_port_arbiter: directed bench with a one-cycle-latency RAM model on port A.
module tb_framebuffer_port_arbiter;
  logic clk_in = 1'b0, reset = 1'b0;
  logic r0_req = 0, r0_write = 0, r1_req = 0, r1_write = 0, clear_start = 0;
  logic [11:0] r0_address = '0, r1_address = '0;
  logic [7:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_ack, r0_rdata_valid, r1_ack, r1_rdata_valid, clear_busy, clear_done;
  logic ram_write_enable, ram_clk_enable;
  logic [7:0] r0_rdata, r1_rdata, ram_data_out, ram_data_in;
  logic [11:0] ram_address;
  logic [7:0] mem [4096];
  int checks = 0, errors = 0;

  framebuffer_port_arbiter #(.DEPTH(16), .CLEAR_VALUE(8'h3C)) dut (
    .clk_in(clk_in), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_rdata_valid(r0_rdata_valid),
    .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_rdata_valid(r1_rdata_valid),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_data_out(ram_data_out), .ram_address(ram_address),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .ram_data_in(ram_data_in));

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    if (ram_clk_enable) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_out;
      ram_data_in <= mem[ram_address];
    end

  wire [55:0] all_out = {r0_ack, r0_rdata, r0_rdata_valid, r1_ack, r1_rdata, r1_rdata_valid,
                         clear_busy, clear_done, ram_data_out, ram_address, ram_write_enable,
                         ram_clk_enable, 6'd0};

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    {r0_req, r1_req, r0_write, r1_write, clear_start} = '0;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (all_out !== 56'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d outputs %h expected 0", i, all_out);
      end
    end
  endtask

  task automatic test_write_read;
    r0_req = 1; r0_write = 1; r0_address = 12'h123; r0_wdata = 8'hA5;
    tick;
    checks++;
    if ({r0_ack, r1_ack, ram_address, ram_data_out, ram_write_enable, ram_clk_enable} !== {2'b10, 12'h123, 8'hA5, 2'b11}) begin
      errors++;
      $display("FAIL write_issue ack0/ack1/addr/data/we/ce got %b %b %h %h %b %b expected 1 0 123 a5 1 1",
               r0_ack, r1_ack, ram_address, ram_data_out, ram_write_enable, ram_clk_enable);
    end
    r0_req = 0;
    tick;
    checks++;
    if ({r0_ack, ram_clk_enable, ram_write_enable} !== 3'b000) begin
      errors++;
      $display("FAIL write_idle ack/ce/we got %b%b%b expected 000", r0_ack, ram_clk_enable, ram_write_enable);
    end
    r0_req = 1; r0_write = 0;
    tick;
    checks++;
    if ({r0_ack, ram_address, ram_write_enable, ram_clk_enable} !== {1'b1, 12'h123, 2'b01}) begin
      errors++;
      $display("FAIL read_issue ack/addr/we/ce got %b %h %b %b expected 1 123 0 1", r0_ack, ram_address, ram_write_enable, ram_clk_enable);
    end
    r0_req = 0;
    tick;
    checks++;
    if ({r0_rdata_valid, r1_rdata_valid, r0_rdata} !== {2'b10, 8'hA5}) begin
      errors++;
      $display("FAIL read_data valid0/valid1/rdata got %b %b %h expected 1 0 a5", r0_rdata_valid, r1_rdata_valid, r0_rdata);
    end
    tick;
    checks++;
    if ({r0_rdata_valid, r0_rdata} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL read_hold valid/rdata got %b %h expected 0 a5", r0_rdata_valid, r0_rdata);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    tick;
    r0_req = 1; r0_write = 1; r0_address = 12'h010; r0_wdata = 8'h11;
    r1_req = 1; r1_write = 1; r1_address = 12'h020; r1_wdata = 8'h22;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++;
      if ({r1_ack, r0_ack, ram_clk_enable, ram_address} !== ((i % 2) ? {3'b101, 12'h020} : {3'b011, 12'h010})) begin
        errors++;
        $display("FAIL alternate cycle %0d ack1/ack0/ce/addr got %b%b %b %h", i, r1_ack, r0_ack, ram_clk_enable, ram_address);
      end
    end
    r0_req = 0; r1_req = 0;
    tick;
    tick;
  endtask

  task automatic test_clear;
    clear_start = 1;
    r1_req = 1; r1_write = 0; r1_address = 12'd7;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (i == 0 || i == 6) clear_start = 0;
      checks++;
      if ({clear_busy, clear_done, r1_ack, ram_address, ram_data_out, ram_write_enable, ram_clk_enable} !==
          {3'b100, 12'(i), 8'h3C, 2'b11}) begin
        errors++;
        $display("FAIL clear_write %0d busy/done/ack1/addr/data/we/ce got %b %b %b %h %h %b %b expected 1 0 0 %h 3c 1 1",
                 i, clear_busy, clear_done, r1_ack, ram_address, ram_data_out, ram_write_enable, ram_clk_enable, i);
      end
      if (i == 5) clear_start = 1;
    end
    tick;
    checks++;
    if ({clear_busy, clear_done, r1_ack, ram_clk_enable} !== 4'b0100) begin
      errors++;
      $display("FAIL clear_done busy/done/ack1/ce got %b%b%b%b expected 0100", clear_busy, clear_done, r1_ack, ram_clk_enable);
    end
    tick;
    checks++;
    if ({clear_done, r1_ack, ram_address, ram_write_enable} !== {2'b01, 12'd7, 1'b0}) begin
      errors++;
      $display("FAIL pending_read done/ack1/addr/we got %b %b %h %b expected 0 1 007 0", clear_done, r1_ack, ram_address, ram_write_enable);
    end
    r1_req = 0;
    tick;
    checks++;
    if ({r1_rdata_valid, r0_rdata_valid, r1_rdata} !== {2'b10, 8'h3C}) begin
      errors++;
      $display("FAIL pending_data valid1/valid0/rdata got %b %b %h expected 1 0 3c", r1_rdata_valid, r0_rdata_valid, r1_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({clear_busy, clear_done} !== 2'b00) begin
        errors++;
        $display("FAIL clear_single cycle %0d busy/done got %b%b expected 00", i, clear_busy, clear_done);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    clear_start = 1;
    tick;
    clear_start = 0;
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if ({clear_busy, ram_address} !== {1'b1, 12'd5}) begin
      errors++;
      $display("FAIL abort_setup busy/addr got %b %h expected 1 005", clear_busy, ram_address);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (all_out !== 56'd0) begin
      errors++;
      $display("FAIL async_reset outputs %h expected 0", all_out);
    end
    tick;
    tick;
    reset = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if ({clear_busy, clear_done, ram_clk_enable} !== 3'b000) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d busy/done/ce got %b%b%b expected 000", i, clear_busy, clear_done, ram_clk_enable);
      end
    end
    r0_req = 1; r0_write = 1; r0_address = 12'h055; r0_wdata = 8'h77;
    tick;
    checks++;
    if ({r0_ack, ram_address, ram_data_out, ram_write_enable} !== {1'b1, 12'h055, 8'h77, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_write ack/addr/data/we got %b %h %h %b expected 1 055 77 1", r0_ack, ram_address, ram_data_out, ram_write_enable);
    end
    r0_req = 0;
    tick;
    r0_req = 1; r0_write = 0;
    tick;
    r0_req = 0;
    tick;
    checks++;
    if ({r0_rdata_valid, r0_rdata} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL post_reset_read valid/rdata got %b %h expected 1 77", r0_rdata_valid, r0_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_clear;
    test_reset_mid_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
